// File: rtl/quiz_pkg.sv
// Shared types and helpers for the quiz-buzzer arbiter: FSM state encoding,
// countdown digit width and the lowest-index key priority encoder.
package quiz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam int CD_DIGIT_W = 3;
  localparam logic [CD_DIGIT_W-1:0] CD_LAST_DIGIT = 3'd6;

  // Encoder is sized for the widest supported key bank; callers zero-extend.
  localparam int MAX_PLAYERS = 8;
  localparam int MAX_ID_W    = 3;

  function automatic logic [MAX_ID_W-1:0] lowest_set(input logic [MAX_PLAYERS-1:0] vec);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
      if (vec[i]) idx = MAX_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchroniser plus delay flop for the raw contestant keys, with a
// registered single-cycle rising-edge pulse per key.
module key_edge_sync #(
  parameter int N = 4
) (
  input  logic         CP,
  input  logic         nCR,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_rise
);

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] sync3;

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      sync1    <= '0;
      sync2    <= '0;
      sync3    <= '0;
      key_rise <= '0;
    end else begin
      sync1    <= key;
      sync2    <= sync1;
      sync3    <= sync2;
      key_rise <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/quiz_arbiter.sv
// Contestant arbiter and countdown master for the quiz buzzer.
// Build option: QUIZ_FOUL_DETECT_EN enables sticky early-press (foul) capture in IDLE.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for host start; timer disabled
// ST_ARMED   | countdown running, first key rise wins
// ST_LOCKED  | winner latched, everything but clear ignored
// ST_TIMEOUT | timer expired without a press, everything but clear ignored
module quiz_arbiter
  import quiz_pkg::*;
#(
  parameter int N_PLAYERS = 4,
  parameter int ID_W      = 3
) (
  input  logic                  CP,
  input  logic                  nCR,
  input  logic                  start,
  input  logic                  clear,
  input  logic [N_PLAYERS-1:0]  key,
  input  logic                  t_up,
  input  logic [CD_DIGIT_W-1:0] cd_digit,
  output logic                  cd_en,
  output logic [CD_DIGIT_W-1:0] disp_digit,
  output logic                  winner_valid,
  output logic [ID_W-1:0]       winner_id,
  output logic                  timeout,
  output logic                  foul_valid,
  output logic [ID_W-1:0]       foul_id
);

  state_t               state;
  logic [N_PLAYERS-1:0] key_rise;
  logic                 any_rise;
  logic [MAX_ID_W-1:0]  rise_low;
  logic [ID_W-1:0]      rise_id;

  key_edge_sync #(.N(N_PLAYERS)) u_key_edge_sync (
    .CP       (CP),
    .nCR      (nCR),
    .key      (key),
    .key_rise (key_rise)
  );

  assign any_rise = |key_rise;
  assign rise_low = lowest_set(MAX_PLAYERS'(key_rise));
  assign rise_id  = ID_W'(rise_low);

`ifndef QUIZ_FOUL_DETECT_EN
  assign foul_valid = 1'b0;
  assign foul_id    = '0;
`endif

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state        <= ST_IDLE;
      cd_en        <= 1'b0;
      disp_digit   <= '0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      timeout      <= 1'b0;
`ifdef QUIZ_FOUL_DETECT_EN
      foul_valid   <= 1'b0;
      foul_id      <= '0;
`endif
    end else if (clear) begin
      state        <= ST_IDLE;
      cd_en        <= 1'b0;
      disp_digit   <= '0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      timeout      <= 1'b0;
`ifdef QUIZ_FOUL_DETECT_EN
      foul_valid   <= 1'b0;
      foul_id      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef QUIZ_FOUL_DETECT_EN
          // A press in IDLE blocks the round; the first offender is kept.
          if (any_rise) begin
            if (!foul_valid) begin
              foul_valid <= 1'b1;
              foul_id    <= rise_id;
            end
          end else if (start && !foul_valid) begin
            state <= ST_ARMED;
            cd_en <= 1'b1;
          end
`else
          if (start) begin
            state <= ST_ARMED;
            cd_en <= 1'b1;
          end
`endif
        end
        ST_ARMED: begin
          disp_digit <= cd_digit;
          // A key rise beats a coincident timeout.
          if (any_rise) begin
            state        <= ST_LOCKED;
            cd_en        <= 1'b0;
            winner_valid <= 1'b1;
            winner_id    <= rise_id;
          end else if (t_up) begin
            state   <= ST_TIMEOUT;
            cd_en   <= 1'b0;
            timeout <= 1'b1;
          end
        end
        ST_LOCKED, ST_TIMEOUT: begin
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_arbiter.sv
// Self-checking bench for quiz_arbiter: directed scenarios plus random key,
// start, clear and timeout traffic against a key-history reference model.
module tb_quiz_arbiter;

  localparam int N  = 4;
  localparam int IW = 3;

  localparam int PH_IDLE    = 0;
  localparam int PH_ARMED   = 1;
  localparam int PH_LOCKED  = 2;
  localparam int PH_TIMEOUT = 3;

  logic          CP = 1'b0;
  logic          nCR = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          t_up = 1'b0;
  logic [N-1:0]  key = '0;
  logic [2:0]    cd_digit = '0;
  logic          cd_en;
  logic [2:0]    disp_digit;
  logic          winner_valid;
  logic [IW-1:0] winner_id;
  logic          timeout;
  logic          foul_valid;
  logic [IW-1:0] foul_id;

  quiz_arbiter #(.N_PLAYERS(N), .ID_W(IW)) dut (
    .CP           (CP),
    .nCR          (nCR),
    .start        (start),
    .clear        (clear),
    .key          (key),
    .t_up         (t_up),
    .cd_digit     (cd_digit),
    .cd_en        (cd_en),
    .disp_digit   (disp_digit),
    .winner_valid (winner_valid),
    .winner_id    (winner_id),
    .timeout      (timeout),
    .foul_valid   (foul_valid),
    .foul_id      (foul_id)
  );

  always #5 CP = ~CP;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a press sampled at posedge e is seen by the arbiter at e+3.
  logic [N-1:0]  hist [5];
  int            m_phase;
  logic          m_cd_en;
  logic [2:0]    m_disp;
  logic          m_wv;
  logic [IW-1:0] m_wid;
  logic          m_to;
  logic          m_fv;
  logic [IW-1:0] m_fid;

  function automatic logic [IW-1:0] first_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return IW'(i);
    return '0;
  endfunction

  task automatic model_clear_outputs();
    m_phase = PH_IDLE;
    m_cd_en = 1'b0;
    m_disp  = '0;
    m_wv    = 1'b0;
    m_wid   = '0;
    m_to    = 1'b0;
    m_fv    = 1'b0;
    m_fid   = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) hist[i] = '0;
    model_clear_outputs();
  endtask

  task automatic model_edge();
    logic [N-1:0] r;
    for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = key;
    r = hist[3] & ~hist[4];
    if (clear) begin
      model_clear_outputs();
    end else if (m_phase == PH_IDLE) begin
`ifdef QUIZ_FOUL_DETECT_EN
      if (r != '0) begin
        if (!m_fv) begin
          m_fv  = 1'b1;
          m_fid = first_of(r);
        end
      end else if (start && !m_fv) begin
        m_phase = PH_ARMED;
        m_cd_en = 1'b1;
      end
`else
      if (start) begin
        m_phase = PH_ARMED;
        m_cd_en = 1'b1;
      end
`endif
    end else if (m_phase == PH_ARMED) begin
      m_disp = cd_digit;
      if (r != '0) begin
        m_phase = PH_LOCKED;
        m_cd_en = 1'b0;
        m_wv    = 1'b1;
        m_wid   = first_of(r);
      end else if (t_up) begin
        m_phase = PH_TIMEOUT;
        m_cd_en = 1'b0;
        m_to    = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("cd_en",        8'(cd_en),        8'(m_cd_en));
    chk("disp_digit",   8'(disp_digit),   8'(m_disp));
    chk("winner_valid", 8'(winner_valid), 8'(m_wv));
    chk("winner_id",    8'(winner_id),    8'(m_wid));
    chk("timeout",      8'(timeout),      8'(m_to));
    chk("foul_valid",   8'(foul_valid),   8'(m_fv));
    chk("foul_id",      8'(foul_id),      8'(m_fid));
  endtask

  task automatic step();
    @(posedge CP);
    if (nCR) model_edge();
    else     model_reset();
    @(negedge CP);
    check_all();
  endtask

  task automatic do_clear();
    key   = '0;
    t_up  = 1'b0;
    start = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int cnt;
  int idx;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge CP);
    check_all();
    chk("rst_cd_en", 8'(cd_en), 8'd0);
    nCR = 1'b1;

    // Countdown runs 7 cycles, then timeout.
    do_start();
    cnt = int'(cd_en);
    repeat (6) begin
      cd_digit = 3'(6 - cnt);
      step();
      cnt += int'(cd_en);
    end
    chk("cd_en_cycles", 8'(cnt), 8'd7);
    t_up = 1'b1;
    step();
    chk("to_timeout", 8'(timeout), 8'd1);
    chk("to_cd_en", 8'(cd_en), 8'd0);
    chk("to_winner", 8'(winner_valid), 8'd0);
    do_clear();

    // key[2] wins with 3-cycle latency; later key[0] ignored.
    do_start();
    key = 4'b0100;
    repeat (3) step();
    chk("k2_latency", 8'(winner_valid), 8'd0);
    step();
    chk("k2_valid", 8'(winner_valid), 8'd1);
    chk("k2_id", 8'(winner_id), 8'd2);
    chk("k2_cd_en", 8'(cd_en), 8'd0);
    key = '0;
    repeat (2) step();
    key = 4'b0001;
    repeat (5) step();
    chk("k2_held", 8'(winner_id), 8'd2);
    do_clear();

    // Simultaneous key[1] and key[3].
    do_start();
    key = 4'b1010;
    repeat (4) step();
    chk("k13_id", 8'(winner_id), 8'd1);
    do_clear();

    // key[0] rise coincident with t_up.
    do_start();
    key = 4'b0001;
    repeat (3) step();
    t_up = 1'b1;
    step();
    chk("tie_valid", 8'(winner_valid), 8'd1);
    chk("tie_id", 8'(winner_id), 8'd0);
    chk("tie_timeout", 8'(timeout), 8'd0);
    do_clear();

    // Key held through start never wins.
    key = 4'b0100;
    repeat (5) step();
    do_start();
    repeat (5) step();
    chk("held_no_win", 8'(winner_valid), 8'd0);
    do_clear();

`ifdef QUIZ_FOUL_DETECT_EN
    key = 4'b1000;
    repeat (4) step();
    chk("foul_valid_set", 8'(foul_valid), 8'd1);
    chk("foul_id_set", 8'(foul_id), 8'd3);
    key = '0;
    do_start();
    chk("foul_blocks", 8'(cd_en), 8'd0);
    do_clear();
    chk("foul_cleared", 8'(foul_valid), 8'd0);
    do_start();
    chk("foul_rearm", 8'(cd_en), 8'd1);
    do_clear();
`endif

    // Asynchronous reset mid-ARMED.
    do_start();
    repeat (2) step();
    #2 nCR = 1'b0;
    #1;
    chk("arst_cd_en", 8'(cd_en), 8'd0);
    model_reset();
    check_all();
    @(negedge CP);
    check_all();
    nCR = 1'b1;

    // Random traffic.
    repeat (1500) begin
      start    = ($urandom_range(0, 7) == 0);
      clear    = ($urandom_range(0, 49) == 0);
      t_up     = ($urandom_range(0, 11) == 0);
      cd_digit = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(0, N - 1));
        key[idx] = ~key[idx];
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
